// File: rtl/rotary_encoder_ctrl.sv
// rtl/rotary_encoder_ctrl.sv - debounced quadrature encoder and pushbutton front end
//
// Purpose: synchronise and debounce three raw pulled-up pins, decode the A/B
// quadrature pair into detent steps driving a wrap/saturate position counter,
// and turn the debounced button into a level plus press/release strobes.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   enc_a/enc_b  raw encoder channels, idle high
//   btn_n        raw pushbutton, active-low
//   pos_load     load pos from pos_din this cycle (wins over a detent)
//   pos_din      value loaded on pos_load
//   pos          current position
//   step_up/dn   one-cycle strobes, one detent clockwise / counter-clockwise
//   btn_level    debounced button, 1 = pressed
//   btn_press    one-cycle strobe on debounced press
//   btn_release  one-cycle strobe on debounced release
//   quad_err     sticky flag: both A and B changed together
module rotary_encoder_ctrl #(
    parameter int DEB_BITS         = 9,
    parameter int POS_WIDTH        = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter bit WRAP             = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 btn_n,
    input  logic                 pos_load,
    input  logic [POS_WIDTH-1:0] pos_din,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 btn_level,
    output logic                 btn_press,
    output logic                 btn_release,
    output logic                 quad_err
);

    localparam logic [DEB_BITS-1:0]  CNT_MAX = '1;
    localparam logic signed [2:0]    SUB_MAX = 3'(STEPS_PER_DETENT - 1);
    localparam logic signed [2:0]    SUB_MIN = -SUB_MAX;
    localparam logic [POS_WIDTH-1:0] POS_MAX = '1;

    // Channel order: 0 = A, 1 = B, 2 = button. All idle high.
    logic [2:0]          w_raw;
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_deb;
    logic [DEB_BITS-1:0] r_cnt [3];

    assign w_raw = {btn_n, enc_b, enc_a};

    // A channel only flips after 2^DEB_BITS consecutive clocks disagreeing
    // with its debounced state; any agreeing clock restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0]          w_ab;
    logic [1:0]          r_prev_ab;
    logic signed [2:0]   r_sub;
    logic                r_btn_prev;
    logic                w_fwd;
    logic                w_rev;
    logic                w_err;
    logic                w_detent_up;
    logic                w_detent_dn;
    logic [POS_WIDTH-1:0] w_pos_up;
    logic [POS_WIDTH-1:0] w_pos_dn;

    assign w_ab = {r_deb[0], r_deb[1]};

    // Gray-code walk 00->10->11->01->00 is clockwise; the reverse walk is
    // counter-clockwise. Unchanged or double-bit changes decode to neither.
    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        case ({r_prev_ab, w_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_rev = 1'b1;
            default: ;
        endcase
    end

    assign w_err = ((w_ab ^ r_prev_ab) == 2'b11);

    // sub never stores +/-STEPS_PER_DETENT: the transition that would reach
    // it is the detent itself, so sub stays within a 3-bit signed range.
    assign w_detent_up = w_fwd && (r_sub == SUB_MAX);
    assign w_detent_dn = w_rev && (r_sub == SUB_MIN);

    assign w_pos_up = (!WRAP && (pos == POS_MAX))  ? pos : pos + 1'b1;
    assign w_pos_dn = (!WRAP && (pos == '0))       ? pos : pos - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_ab   <= 2'b11;
            r_sub       <= '0;
            pos         <= '0;
            step_up     <= 1'b0;
            step_dn     <= 1'b0;
            quad_err    <= 1'b0;
            r_btn_prev  <= 1'b1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            r_prev_ab <= w_ab;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;

            if (w_err) begin
                quad_err <= 1'b1;
            end

            if (pos_load) begin
                pos   <= pos_din;
                r_sub <= '0;
            end else if (w_detent_up) begin
                pos     <= w_pos_up;
                r_sub   <= '0;
                step_up <= 1'b1;
            end else if (w_detent_dn) begin
                pos     <= w_pos_dn;
                r_sub   <= '0;
                step_dn <= 1'b1;
            end else if (w_fwd) begin
                r_sub <= r_sub + 3'sd1;
            end else if (w_rev) begin
                r_sub <= r_sub - 3'sd1;
            end

            // Button is active-low: a debounced 1->0 is a press.
            r_btn_prev  <= r_deb[2];
            btn_press   <= r_btn_prev & ~r_deb[2];
            btn_release <= ~r_btn_prev & r_deb[2];
        end
    end

    assign btn_level = ~r_deb[2];

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// tb/tb_rotary_encoder_ctrl.sv - self-checking bench for rotary_encoder_ctrl
module tb_rotary_encoder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_a, enc_b, btn_n, pos_load;
    logic [3:0] pos_din;
    logic [3:0] pos, pos_nw;
    logic       step_up, step_dn, btn_level, btn_press, btn_release, quad_err;
    logic       up_nw, dn_nw, lvl_nw, pr_nw, rl_nw, err_nw;

    always #5 clk = ~clk;

    rotary_encoder_ctrl #(.DEB_BITS(2), .POS_WIDTH(4), .STEPS_PER_DETENT(4), .WRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn_n(btn_n),
        .pos_load(pos_load), .pos_din(pos_din), .pos(pos),
        .step_up(step_up), .step_dn(step_dn), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .quad_err(quad_err)
    );

    rotary_encoder_ctrl #(.DEB_BITS(2), .POS_WIDTH(4), .STEPS_PER_DETENT(4), .WRAP(1'b0)) dut_nw (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn_n(btn_n),
        .pos_load(pos_load), .pos_din(pos_din), .pos(pos_nw),
        .step_up(up_nw), .step_dn(dn_nw), .btn_level(lvl_nw),
        .btn_press(pr_nw), .btn_release(rl_nw), .quad_err(err_nw)
    );

    typedef struct {
        string      name;
        logic       a, b, btn, load;
        logic [3:0] din;
        int         clks;
        int         up, dn, pr, rl;
        logic [3:0] pos_w, pos_s;
        logic       err, lvl;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input string name, input logic a, input logic b, input logic btn,
                       input logic load, input logic [3:0] din, input int clks,
                       input int up, input int dn, input int pr, input int rl,
                       input logic [3:0] pw, input logic [3:0] ps, input logic err, input logic lvl);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.btn = btn; v.load = load; v.din = din;
        v.clks = clks; v.up = up; v.dn = dn; v.pr = pr; v.rl = rl;
        v.pos_w = pw; v.pos_s = ps; v.err = err; v.lvl = lvl;
        vecs.push_back(v);
    endtask

    // Inputs are driven 1 time unit after a rising edge; load lasts one edge.
    task automatic run_row(input int idx);
        vec_t v;
        int up = 0, dn = 0, pr = 0, rl = 0, upn = 0, dnn = 0;
        v = vecs[idx];
        enc_a = v.a; enc_b = v.b; btn_n = v.btn; pos_load = v.load; pos_din = v.din;
        for (int k = 0; k < v.clks; k++) begin
            @(posedge clk); #1;
            pos_load = 1'b0;
            up  += int'(step_up);  dn  += int'(step_dn);
            pr  += int'(btn_press); rl += int'(btn_release);
            upn += int'(up_nw);    dnn += int'(dn_nw);
        end
        chk({v.name, " step_up"}, idx, up, v.up);
        chk({v.name, " step_dn"}, idx, dn, v.dn);
        chk({v.name, " sat step_up"}, idx, upn, v.up);
        chk({v.name, " sat step_dn"}, idx, dnn, v.dn);
        chk({v.name, " press"}, idx, pr, v.pr);
        chk({v.name, " release"}, idx, rl, v.rl);
        chk({v.name, " pos wrap"}, idx, int'(pos), int'(v.pos_w));
        chk({v.name, " pos sat"}, idx, int'(pos_nw), int'(v.pos_s));
        chk({v.name, " quad_err"}, idx, int'(quad_err), int'(v.err));
        chk({v.name, " btn_level"}, idx, int'(btn_level), int'(v.lvl));
    endtask

    initial begin
        int seg_b, seg_c, seg_end;
        int e_up, e_pr, e_upn, c_up, c_pr, c_upn;

        // Segment A: release after the hand-driven press.
        add("btn_release", 1, 1, 1, 0, 0, 12, 0, 0, 0, 1, 0, 0, 0, 0);
        seg_b = vecs.size();
        // One forward detent 11->01->00->10->11.
        add("fwd1", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add("fwd2", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add("fwd3", 1, 0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        add("fwd4", 1, 1, 1, 0, 0, 10, 1, 0, 0, 0, 1, 1, 0, 0);
        // Five reverse detents from pos 1: wrap 0,15,14,13,12; saturate stays 0.
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] pb, pa;
            pb = 4'(2 - k);
            pa = 4'(1 - k);
            add("rev1", 1, 0, 1, 0, 0, 10, 0, 0, 0, 0, pb, (k == 1) ? 4'd1 : 4'd0, 0, 0);
            add("rev2", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, pb, (k == 1) ? 4'd1 : 4'd0, 0, 0);
            add("rev3", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, pb, (k == 1) ? 4'd1 : 4'd0, 0, 0);
            add("rev4", 1, 1, 1, 0, 0, 10, 0, 1, 0, 0, pa, 4'd0, 0, 0);
        end
        // Half detent forward then back: no pulse.
        add("half1", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, 12, 0, 0, 0);
        add("half2", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, 12, 0, 0, 0);
        add("half3", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, 12, 0, 0, 0);
        add("half4", 1, 1, 1, 0, 0, 10, 0, 0, 0, 0, 12, 0, 0, 0);
        // Load max, then step up: wrap to 0 vs hold at 15 with pulse.
        add("load15", 1, 1, 1, 1, 15, 3, 0, 0, 0, 0, 15, 15, 0, 0);
        add("max1", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, 15, 15, 0, 0);
        add("max2", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, 15, 15, 0, 0);
        add("max3", 1, 0, 1, 0, 0, 10, 0, 0, 0, 0, 15, 15, 0, 0);
        add("max4", 1, 1, 1, 0, 0, 10, 1, 0, 0, 0, 0, 15, 0, 0);
        // Double transitions set the sticky error without counting.
        add("err_11_00", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 15, 1, 0);
        add("err_00_11", 1, 1, 1, 0, 0, 10, 0, 0, 0, 0, 0, 15, 1, 0);
        add("pre6a_1", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, 0, 15, 1, 0);
        add("pre6a_2", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 15, 1, 0);
        add("pre6a_3", 1, 0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 15, 1, 0);
        seg_c = vecs.size();
        add("btn_release2", 1, 0, 1, 0, 0, 12, 0, 0, 0, 1, 1, 15, 1, 0);
        add("pre6b_1", 1, 1, 1, 0, 0, 10, 0, 0, 0, 0, 1, 15, 1, 0);
        add("pre6b_2", 0, 1, 1, 0, 0, 10, 0, 0, 0, 0, 1, 15, 1, 0);
        add("pre6b_3", 0, 0, 1, 0, 0, 10, 0, 0, 0, 0, 1, 15, 1, 0);
        add("pre6b_4", 1, 0, 1, 0, 0, 10, 0, 0, 0, 0, 1, 15, 1, 0);
        seg_end = vecs.size();

        rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; btn_n = 1'b1; pos_load = 1'b0; pos_din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pos", 0, int'(pos), 0);
        chk("reset step_up", 0, int'(step_up), 0);
        chk("reset step_dn", 0, int'(step_dn), 0);
        chk("reset btn_level", 0, int'(btn_level), 0);
        chk("reset btn_press", 0, int'(btn_press), 0);
        chk("reset btn_release", 0, int'(btn_release), 0);
        chk("reset quad_err", 0, int'(quad_err), 0);
        rst = 1'b0;

        // 3-clock glitch on the button: no press.
        btn_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        btn_n = 1'b1;
        c_pr = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            c_pr += int'(btn_press);
        end
        chk("glitch press", 0, c_pr, 0);
        chk("glitch level", 0, int'(btn_level), 0);

        // Held press: strobe on the 7th edge counting the first sampling edge.
        btn_n = 1'b0;
        e_pr = -1; c_pr = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (btn_press) begin
                c_pr++;
                e_pr = k;
            end
        end
        chk("press edge", 0, e_pr, 7);
        chk("press count", 0, c_pr, 1);
        chk("press level", 0, int'(btn_level), 1);

        for (int i = 0; i < seg_c; i++) run_row(i);

        // Final detent transition and button press together: same-cycle strobes,
        // saturating instance still pulses while holding at 15.
        enc_a = 1'b1; enc_b = 1'b1; btn_n = 1'b0;
        e_up = -1; e_pr = -1; e_upn = -1; c_up = 0; c_pr = 0; c_upn = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (step_up)   begin c_up++;  e_up  = k; end
            if (btn_press) begin c_pr++;  e_pr  = k; end
            if (up_nw)     begin c_upn++; e_upn = k; end
        end
        chk("sim step edge", 0, e_up, 7);
        chk("sim press edge", 0, e_pr, 7);
        chk("sim sat step edge", 0, e_upn, 7);
        chk("sim step count", 0, c_up + c_upn, 2);
        chk("sim press count", 0, c_pr, 1);
        chk("sim pos wrap", 0, int'(pos), 1);
        chk("sim pos sat", 0, int'(pos_nw), 15);

        for (int i = seg_c; i < seg_end; i++) run_row(i);

        // Load in the cycle the detent completes: load wins, no strobe.
        enc_a = 1'b1; enc_b = 1'b1;
        c_up = 0;
        repeat (6) @(posedge clk);
        #1;
        pos_load = 1'b1; pos_din = 4'd9;
        @(posedge clk); #1;
        pos_load = 1'b0;
        c_up += int'(step_up) + int'(up_nw);
        chk("load pos wrap", 0, int'(pos), 9);
        chk("load pos sat", 0, int'(pos_nw), 9);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            c_up += int'(step_up) + int'(up_nw);
        end
        chk("load step suppressed", 0, c_up, 0);
        chk("load pos hold", 0, int'(pos), 9);

        // Reset in the middle of a debounce.
        btn_n = 1'b0; enc_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; btn_n = 1'b1; enc_a = 1'b1;
        @(posedge clk); #1;
        chk("rst pos", 0, int'(pos), 0);
        chk("rst pos sat", 0, int'(pos_nw), 0);
        chk("rst quad_err", 0, int'(quad_err), 0);
        chk("rst btn_level", 0, int'(btn_level), 0);
        chk("rst strobes", 0, int'(step_up) + int'(step_dn) + int'(btn_press) + int'(btn_release), 0);
        rst = 1'b0;
        c_pr = 0; c_up = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            c_pr += int'(btn_press) + int'(btn_release);
            c_up += int'(step_up) + int'(step_dn);
        end
        chk("post rst btn strobes", 0, c_pr, 0);
        chk("post rst step strobes", 0, c_up, 0);
        chk("post rst pos", 0, int'(pos), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
